// File: rtl/jk_seq_driver.sv
// Command-driven stimulus source and checker for a WIDTH-bit bank of JK flip-flops.
// Each command is accepted, drives one cycle of J/K excitation, then compares the bank against EXP.
module jk_seq_driver #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [1:0]       CMD,
   input  logic [WIDTH-1:0] TGT,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic             INJ,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] EXP,
   output logic             DONE,
   output logic             ERR
);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

   state_t           state;
   logic [1:0]       cmd_r;
   logic [WIDTH-1:0] tgt_r;
   logic [WIDTH-1:0] j_next;
   logic [WIDTH-1:0] k_next;
   logic [WIDTH-1:0] exp_next;

   // Excitation is combinational so INJ can override bit 0 for the whole DRIVE cycle
   always_comb begin
      j_next = '0;
      k_next = '0;
      if (state == DRIVE) begin
         case (cmd_r)
            2'b00: begin
               j_next = tgt_r & ~Q;
               k_next = ~tgt_r & Q;
            end
            2'b01: begin
               j_next = '0;
               k_next = '0;
            end
            2'b10: begin
               j_next = '1;
               k_next = '1;
            end
            default: begin
               j_next = '0;
               k_next = '1;
            end
         endcase
         if (INJ) begin
            j_next[0] = 1'b0;
            k_next[0] = 1'b0;
         end
      end
   end

   always_comb begin
      exp_next = '0;
      case (CMD)
         2'b00:   exp_next = TGT;
         2'b01:   exp_next = Q;
         2'b10:   exp_next = ~Q;
         default: exp_next = '0;
      endcase
   end

   assign J = j_next;
   assign K = k_next;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cmd_r     <= 2'b00;
         tgt_r     <= '0;
         Q         <= '0;
         EXP       <= '0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         CMD_READY <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (CMD_VALID) begin
                  cmd_r     <= CMD;
                  tgt_r     <= TGT;
                  EXP       <= exp_next;
                  CMD_READY <= 1'b0;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               // Standard JK next-state: set where J and not Q, keep where Q and not K
               Q     <= (j_next & ~Q) | (~k_next & Q);
               DONE  <= 1'b1;
               state <= CHECK;
            end
            CHECK: begin
               DONE      <= 1'b0;
               CMD_READY <= 1'b1;
               if (Q != EXP) begin
                  ERR <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               DONE      <= 1'b0;
               CMD_READY <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Scoreboard bench for jk_seq_driver: the driver pushes expected results on acceptance,
// a negedge monitor pops and checks them whenever DONE is seen.
module tb_jk_seq_driver;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST;
   logic [1:0]   CMD;
   logic [W-1:0] TGT;
   logic         CMD_VALID;
   logic         CMD_READY;
   logic         INJ;
   logic [W-1:0] J;
   logic [W-1:0] K;
   logic [W-1:0] Q;
   logic [W-1:0] EXP;
   logic         DONE;
   logic         ERR;

   jk_seq_driver #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .CMD(CMD), .TGT(TGT), .CMD_VALID(CMD_VALID),
      .CMD_READY(CMD_READY), .INJ(INJ), .J(J), .K(K), .Q(Q), .EXP(EXP),
      .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] q_new;
      logic [W-1:0] exp_v;
      logic [W-1:0] j;
      logic [W-1:0] k;
      logic         err_before;
      logic         err_after;
      int           done_cycle;
   } item_t;

   item_t        sb[$];
   int           cycle = 0;
   int           vectors = 0;
   int           miscompares = 0;
   int           inj_hold = 0;
   logic [W-1:0] ref_q = '0;
   logic         ref_err = 1'b0;
   logic [W-1:0] prev_j = '0;
   logic [W-1:0] prev_k = '0;
   bit           err_pending = 0;
   logic         err_expect = 1'b0;

   always @(posedge CLK) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Intended bank value for a command, from the command definitions
   function automatic logic [W-1:0] intended(input logic [1:0] c, input logic [W-1:0] q, input logic [W-1:0] t);
      case (c)
         2'b00:   return t;
         2'b01:   return q;
         2'b10:   return ~q;
         default: return '0;
      endcase
   endfunction

   function automatic logic [2*W-1:0] excitation(input logic [1:0] c, input logic [W-1:0] q,
                                                 input logic [W-1:0] t, input bit inj);
      logic [W-1:0] jj, kk;
      jj = '0;
      kk = '0;
      for (int i = 0; i < W; i++) begin
         case (c)
            2'b00: begin
               if (!q[i] && t[i]) jj[i] = 1'b1;
               else if (q[i] && !t[i]) kk[i] = 1'b1;
            end
            2'b10: begin
               jj[i] = 1'b1;
               kk[i] = 1'b1;
            end
            2'b11: kk[i] = 1'b1;
            default: ;
         endcase
      end
      if (inj) begin
         jj[0] = 1'b0;
         kk[0] = 1'b0;
      end
      return {jj, kk};
   endfunction

   task automatic applyStimulus(input bit valid, input logic [1:0] c, input logic [W-1:0] t,
                                input bit inj, output bit acc);
      item_t it;
      logic [2*W-1:0] jk;
      @(negedge CLK);
      #1;
      CMD_VALID = valid;
      CMD = c;
      TGT = t;
      if (inj_hold > 0) inj_hold--;
      else INJ = 1'b0;
      acc = valid && CMD_READY;
      if (acc) begin
         INJ = inj;
         inj_hold = 1;
         jk = excitation(c, ref_q, t, inj);
         it.exp_v = intended(c, ref_q, t);
         it.q_new = it.exp_v;
         if (inj) it.q_new[0] = ref_q[0];
         it.j = jk[2*W-1:W];
         it.k = jk[W-1:0];
         it.err_before = ref_err;
         it.err_after = ref_err | (it.q_new != it.exp_v);
         it.done_cycle = cycle + 2;
         sb.push_back(it);
         ref_q = it.q_new;
         ref_err = it.err_after;
      end
   endtask

   task automatic sendCmd(input logic [1:0] c, input logic [W-1:0] t, input bit inj);
      bit acc;
      bit got;
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         applyStimulus(1'b1, c, t, inj, acc);
         got = acc;
      end
      if (!got) checkOutput("accept_timeout", 0, 1);
      applyStimulus(1'b0, 2'b01, '0, 1'b0, acc);
      applyStimulus(1'b0, 2'b01, '0, 1'b0, acc);
   endtask

   task automatic doReset();
      RST = 1'b1;
      CMD_VALID = 1'b0;
      INJ = 1'b0;
      inj_hold = 0;
      @(posedge CLK);
      @(negedge CLK);
      sb.delete();
      ref_q = '0;
      ref_err = 1'b0;
      #1;
      RST = 1'b0;
   endtask

   // Monitor: pop an expectation whenever the DUT reports a completed check
   always @(negedge CLK) begin
      if (RST) begin
         err_pending = 0;
      end else begin
         if (DONE) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_done", 1, 0);
            end else begin
               item_t it;
               it = sb.pop_front();
               checkOutput("done_cycle", cycle, it.done_cycle);
               checkOutput("check_q", Q, it.q_new);
               checkOutput("check_exp", EXP, it.exp_v);
               checkOutput("drive_j", prev_j, it.j);
               checkOutput("drive_k", prev_k, it.k);
               checkOutput("check_jk_zero", {J, K}, 0);
               checkOutput("check_ready_low", CMD_READY, 0);
               checkOutput("err_before", ERR, it.err_before);
               err_pending = 1;
               err_expect = it.err_after;
            end
         end else if (err_pending) begin
            checkOutput("err_after", ERR, err_expect);
            checkOutput("ready_back", CMD_READY, 1);
            err_pending = 0;
         end
         prev_j = J;
         prev_k = K;
      end
   end

   initial begin
      bit acc;
      bit have_last;
      int last_acc;
      CMD = 2'b00;
      TGT = '0;
      CMD_VALID = 1'b0;
      INJ = 1'b0;
      RST = 1'b0;
      #2;
      doReset();

      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         #1;
         checkOutput("idle_q", Q, 0);
         checkOutput("idle_jk", {J, K}, 0);
         checkOutput("idle_ready", CMD_READY, 1);
         checkOutput("idle_done", DONE, 0);
         checkOutput("idle_err", ERR, 0);
      end

      sendCmd(2'b00, 4'b1010, 1'b0);
      sendCmd(2'b00, 4'b0110, 1'b0);
      sendCmd(2'b10, 4'b0000, 1'b0);
      sendCmd(2'b01, 4'b1111, 1'b0);
      sendCmd(2'b11, 4'b1111, 1'b0);
      sendCmd(2'b00, 4'b0000, 1'b0);

      // Back-to-back: valid held high, acceptances must be spaced by three cycles
      have_last = 0;
      last_acc = 0;
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 1'b0, acc);
         if (acc) begin
            if (have_last) checkOutput("b2b_spacing", cycle - last_acc, 3);
            last_acc = cycle;
            have_last = 1;
         end
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b01, '0, 1'b0, acc);

      // Fault inject, then a clean command must not clear ERR
      doReset();
      sendCmd(2'b00, 4'b0001, 1'b1);
      sendCmd(2'b00, 4'b0011, 1'b0);
      doReset();
      @(negedge CLK);
      #1;
      checkOutput("rst_clears_err", ERR, 0);

      // Reset during DRIVE of a toggle from 0101
      sendCmd(2'b00, 4'b0101, 1'b0);
      acc = 0;
      for (int n = 0; n < 10 && !acc; n++) applyStimulus(1'b1, 2'b10, '0, 1'b0, acc);
      @(negedge CLK);
      #2;
      CMD_VALID = 1'b0;
      RST = 1'b1;
      #1;
      checkOutput("midrst_q", Q, 0);
      checkOutput("midrst_jk", {J, K}, 0);
      checkOutput("midrst_done", DONE, 0);
      checkOutput("midrst_exp", EXP, 0);
      doReset();
      @(negedge CLK);
      #1;
      checkOutput("midrst_ready", CMD_READY, 1);
      checkOutput("midrst_no_done", DONE, 0);

      // Randomized traffic with occasional fault injection
      for (int i = 0; i < 200; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom),
                       $urandom_range(0, 7) == 0, acc);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b01, '0, 1'b0, acc);
      checkOutput("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
